video_ram_arbiter: RTL and testbench

- Sits between the text-mode video controller and the single-port synchronous main RAM (64K x 8, one-cycle read latency).
- Shares that one RAM port between video character fetches and CPU accesses.
- Video fetches have absolute priority and a fixed one-cycle latency, so character data always lands on the cycle the video controller samples it.
- CPU accesses go through a one-entry request buffer with a valid/ready handshake and are slotted into cycles where video is idle.

---
 rtl/video_ram_arbiter.sv | 100 ++++++++++
 tb/tb_video_ram_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_ram_arbiter.sv
// Shares one single-port synchronous RAM between video character fetches (absolute
// priority, fixed 1-cycle latency) and CPU accesses held in a one-entry request buffer.
module video_ram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vid_en,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [DATA_WIDTH-1:0] vid_din,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    logic                  r_buf_valid;
    logic                  r_buf_we;
    logic [ADDR_WIDTH-1:0] r_buf_addr;
    logic [DATA_WIDTH-1:0] r_buf_wdata;
    logic                  r_vid_pend;
    logic                  r_cpu_pend;
    logic [DATA_WIDTH-1:0] r_vid_hold;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic                  r_cpu_rvalid;

    logic w_xfer;
    logic w_buf_issue;

    // The buffer may refill on the very edge it issues, so ready only drops while video blocks it.
    assign cpu_ready   = !r_buf_valid || !vid_en;
    assign w_xfer      = cpu_req && cpu_ready;
    assign w_buf_issue = r_buf_valid && !vid_en;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = r_buf_addr;
        ram_wdata = r_buf_wdata;
        if (vid_en) begin
            ram_en   = 1'b1;
            ram_addr = vid_addr;
        end else if (r_buf_valid) begin
            ram_en = 1'b1;
            ram_we = r_buf_we;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_we    <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_wdata <= '0;
        end else if (w_xfer) begin
            r_buf_valid <= 1'b1;
            r_buf_we    <= cpu_we;
            r_buf_addr  <= cpu_addr;
            r_buf_wdata <= cpu_wdata;
        end else if (w_buf_issue) begin
            r_buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vid_pend   <= 1'b0;
            r_cpu_pend   <= 1'b0;
            r_vid_hold   <= '0;
            r_cpu_rdata  <= '0;
            r_cpu_rvalid <= 1'b0;
        end else begin
            r_vid_pend   <= vid_en;
            r_cpu_pend   <= w_buf_issue && !r_buf_we;
            r_cpu_rvalid <= r_cpu_pend;
            if (r_vid_pend) begin
                r_vid_hold <= ram_rdata;
            end
            if (r_cpu_pend) begin
                r_cpu_rdata <= ram_rdata;
            end
        end
    end

    // Video data is forwarded straight from the RAM on its return cycle to keep latency at one.
    assign vid_din    = r_vid_pend ? ram_rdata : r_vid_hold;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_rvalid = r_cpu_rvalid;

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Randomized bench for video_ram_arbiter: a behavioural RAM plus a transaction-level
// model (request queue, return queue with due cycles, write map) checked every cycle.
module tb_video_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_en;
    logic [15:0] vid_addr;
    logic [7:0]  vid_din;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    video_ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .vid_en(vid_en), .vid_addr(vid_addr), .vid_din(vid_din),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        if (a == 16'hF600) return 8'h41;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Synchronous 64K x 8 RAM, preloaded with pat() on its first clock.
    logic [7:0] mem [0:65535];
    logic       mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
            mem_loaded <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rd;
    } req_t;

    typedef struct {
        logic [7:0] data;
        int         due;
    } ret_t;

    req_t       pendq[$];
    ret_t       retq[$];
    logic [7:0] wr_map [logic [15:0]];
    logic [7:0] exp_vid;
    logic [7:0] exp_cpu_rdata;
    int         cyc;
    int         n_cmp;
    int         n_err;

    function automatic logic [7:0] model_rd(input logic [15:0] a);
        if (wr_map.exists(a)) return wr_map[a];
        return pat(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cpu_set(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    // One clock: check all outputs against the model mid-cycle, then advance the model.
    task automatic tick(output bit accepted);
        int   m;
        bit   e_ready;
        bit   e_rv;
        req_t r;
        @(negedge clk);
        m       = pendq.size();
        e_ready = (m == 0) || !vid_en;
        check("cpu_ready", 32'(cpu_ready), 32'(e_ready));
        if (vid_en) begin
            check("ram_en_vid", 32'(ram_en), 1);
            check("ram_we_vid", 32'(ram_we), 0);
            check("ram_addr_vid", 32'(ram_addr), 32'(vid_addr));
        end else if (m > 0) begin
            check("ram_en_cpu", 32'(ram_en), 1);
            check("ram_we_cpu", 32'(ram_we), 32'(pendq[0].we));
            check("ram_addr_cpu", 32'(ram_addr), 32'(pendq[0].addr));
            if (pendq[0].we) check("ram_wdata", 32'(ram_wdata), 32'(pendq[0].wdata));
        end else begin
            check("ram_en_idle", 32'(ram_en), 0);
            check("ram_we_idle", 32'(ram_we), 0);
        end
        check("vid_din", 32'(vid_din), 32'(exp_vid));
        e_rv = (retq.size() > 0) && (retq[0].due == cyc);
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(e_rv));
        if (e_rv) begin
            exp_cpu_rdata = retq[0].data;
            void'(retq.pop_front());
        end
        check("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rdata));

        if (!vid_en && m > 0) begin
            r = pendq.pop_front();
            if (!r.we) retq.push_back('{data: r.rd, due: cyc + 2});
        end
        accepted = cpu_req && e_ready;
        if (accepted) begin
            r.we    = cpu_we;
            r.addr  = cpu_addr;
            r.wdata = cpu_wdata;
            if (cpu_we) wr_map[cpu_addr] = cpu_wdata;
            r.rd    = model_rd(cpu_addr);
            pendq.push_back(r);
        end
        if (vid_en) exp_vid = model_rd(vid_addr);
        @(posedge clk);
        cyc++;
        #1;
        if (accepted) cpu_req = 1'b0;
    endtask

    task automatic run(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic wait_accept(input string tag);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) tick(acc);
        check(tag, 32'(acc), 1);
    endtask

    initial begin
        bit acc;
        n_cmp = 0; n_err = 0; cyc = 0;
        exp_vid = 8'h00; exp_cpu_rdata = 8'h00;
        rst_n = 1'b0; vid_en = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vid_din", 32'(vid_din), 0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_cpu_ready", 32'(cpu_ready), 1);
        check("rst_ram_en", 32'(ram_en), 0);
        vid_en = 1'b1;
        #1;
        check("rst_ram_en_vid", 32'(ram_en), 1);
        vid_en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read back the same address with video idle.
        cpu_set(1'b1, 16'h1234, 8'h5A);
        wait_accept("t1_wr_accept");
        cpu_set(1'b0, 16'h1234, 8'h00);
        wait_accept("t1_rd_accept");
        run(4);
        check("t1_rdata", 32'(cpu_rdata), 32'h5A);

        // Video fetch result must persist in the hold register.
        vid_en = 1'b1; vid_addr = 16'hF600;
        tick(acc);
        vid_en = 1'b0;
        run(9);
        check("t2_vid_hold", 32'(vid_din), 32'h41);

        // CPU read accepted alongside a video fetch.
        cpu_set(1'b0, 16'h0010, 8'h00);
        vid_en = 1'b1; vid_addr = 16'hF123;
        tick(acc);
        check("t3_accept", 32'(acc), 1);
        vid_en = 1'b0;
        run(4);

        // Buffer full while video blocks it, then back-to-back refill.
        vid_en = 1'b1; vid_addr = 16'hF200;
        cpu_set(1'b0, 16'h0020, 8'h00);
        tick(acc);
        check("t4_first_accept", 32'(acc), 1);
        cpu_set(1'b0, 16'h0021, 8'h00);
        vid_addr = 16'hF201;
        tick(acc);
        check("t4_blocked", 32'(acc), 0);
        vid_en = 1'b0;
        tick(acc);
        check("t4_refill", 32'(acc), 1);
        run(5);

        // Reset while a CPU read is buffered behind video.
        vid_en = 1'b1; vid_addr = 16'hF300;
        cpu_set(1'b0, 16'h0030, 8'h00);
        tick(acc);
        tick(acc);
        rst_n = 1'b0; vid_en = 1'b0; cpu_req = 1'b0;
        pendq.delete(); retq.delete();
        exp_vid = 8'h00; exp_cpu_rdata = 8'h00;
        repeat (3) @(posedge clk);
        cyc += 3;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        check("t5_rvalid", 32'(cpu_rvalid), 0);
        check("t5_ready", 32'(cpu_ready), 1);
        check("t5_vid_din", 32'(vid_din), 0);
        check("t5_ram_en", 32'(ram_en), 0);
        run(5);

        // Random mixed traffic, video at most one cycle in eight.
        for (int i = 0; i < 3000; i++) begin
            vid_en   = ((i % 8) == 3) && ($urandom_range(0, 3) != 0);
            vid_addr = 16'hF000 | 16'($urandom_range(0, 4095));
            if (!cpu_req && $urandom_range(0, 3) != 0)
                cpu_set(1'($urandom_range(0, 1)), 16'($urandom_range(0, 4095)), 8'($urandom()));
            tick(acc);
        end

        // Streaming: video every 8th cycle, CPU reading continuously.
        for (int i = 0; i < 1000; i++) begin
            vid_en   = ((i % 8) == 5);
            vid_addr = 16'hF000 | 16'($urandom_range(0, 4095));
            if (!cpu_req) cpu_set(1'b0, 16'($urandom_range(0, 4095)), 8'h00);
            tick(acc);
        end
        vid_en = 1'b0;
        cpu_req = 1'b0;
        run(6);
        check("drain_pend", 32'(pendq.size()), 0);
        check("drain_ret", 32'(retq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
